// File: rtl/adapter_from_bus_pkg.sv
// rtl/adapter_from_bus_pkg.sv - shared constants and wide-message type for the bus deserializer.
package adapter_from_bus_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int WORDS      = 4;
  localparam int LEN_WIDTH  = 16;
  localparam int OUT_WIDTH  = DATA_WIDTH * WORDS;
  localparam int IDX_WIDTH  = $clog2(WORDS);

  typedef struct packed {
    logic [OUT_WIDTH-1:0] v;
    logic [LEN_WIDTH-1:0] length;
    logic                 overflow;
  } msg_t;

endpackage

// File: rtl/adapter_from_bus_if.sv
// rtl/adapter_from_bus_if.sv - beat-in / wide-message-out ENA/RDY bundle (overflow under ADAPTER_FROM_BUS_OVERFLOW_EN).
interface adapter_from_bus_if;
  import adapter_from_bus_pkg::*;

  logic                  in_enq__ENA;
  logic [DATA_WIDTH-1:0] in_enq_v;
  logic                  in_enq_last;
  logic                  in_enq__RDY;
  logic                  out_enq__ENA;
  logic [OUT_WIDTH-1:0]  out_enq_v;
  logic [LEN_WIDTH-1:0]  out_enq_length;
  logic                  out_enq__RDY;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  logic                  out_enq_overflow;
`endif

  modport slave (
    input  in_enq__ENA, in_enq_v, in_enq_last, out_enq__RDY,
    output in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_length
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
    , output out_enq_overflow
`endif
  );

  modport master (
    output in_enq__ENA, in_enq_v, in_enq_last, out_enq__RDY,
    input  in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_length
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
    , input out_enq_overflow
`endif
  );

endinterface

// File: rtl/adapter_from_bus_hold.sv
// rtl/adapter_from_bus_hold.sv - one-entry output message register with drain-bypass ready.
module adapter_from_bus_hold
  import adapter_from_bus_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  msg_t msg_i,
  input  logic out_rdy_i,
  output logic full_o,
  output logic out_ena_o,
  output logic in_rdy_o,
  output msg_t msg_o
);

  logic full_q, full_d;
  msg_t msg_q, msg_d;

  assign full_o    = full_q;
  assign out_ena_o = full_q & out_rdy_i;
  // A message draining this cycle frees the slot for whatever completes now.
  assign in_rdy_o  = !full_q | out_rdy_i;
  assign msg_o     = msg_q;

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    if (out_ena_o) begin
      full_d         = 1'b0;
      msg_d.overflow = 1'b0;
    end
    if (load_i) begin
      full_d = 1'b1;
      msg_d  = msg_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
    end
  end

endmodule

// File: rtl/adapter_from_bus.sv
// rtl/adapter_from_bus.sv - gathers last-terminated 32-bit beats into one 128-bit message plus length.
// Optional overflow flag: ADAPTER_FROM_BUS_OVERFLOW_EN.
module adapter_from_bus
  import adapter_from_bus_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  adapter_from_bus_if.slave bus
);

  localparam logic [LEN_WIDTH-1:0] WORDS_L = LEN_WIDTH'(WORDS);

  logic [OUT_WIDTH-1:0] buf_q, buf_d, buf_w;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 accept, load, full, out_ena, in_rdy;
  msg_t                 msg_in, msg_out;

  assign accept = bus.in_enq__ENA & in_rdy;

  always_comb begin
    buf_w = buf_q;
    for (int w = 0; w < WORDS; w++) begin
      if (cnt_q == LEN_WIDTH'(w)) buf_w[w*DATA_WIDTH +: DATA_WIDTH] = bus.in_enq_v;
    end
  end

  // Count keeps running past WORDS so length reports the true burst size.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  logic ovf_q, ovf_d, ovf_beat;
  assign ovf_beat = cnt_q >= WORDS_L;
`endif

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    load   = 1'b0;
    msg_in = '0;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
    ovf_d  = ovf_q;
`endif
    if (accept) begin
      buf_d = buf_w;
      cnt_d = cnt_inc;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
      ovf_d = ovf_q | ovf_beat;
`endif
      if (bus.in_enq_last) begin
        load          = 1'b1;
        msg_in.v      = buf_w;
        msg_in.length = cnt_inc - 1'b1;
        buf_d         = '0;
        cnt_d         = '0;
`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
        msg_in.overflow = ovf_q | ovf_beat;
        ovf_d           = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef ADAPTER_FROM_BUS_OVERFLOW_EN
  always_ff @(posedge CLK) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign bus.out_enq_overflow = msg_out.overflow & full;
`else
  logic unused_ovf;
  assign unused_ovf = msg_out.overflow & full;
`endif

  adapter_from_bus_hold u_hold (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (load),
    .msg_i     (msg_in),
    .out_rdy_i (bus.out_enq__RDY),
    .full_o    (full),
    .out_ena_o (out_ena),
    .in_rdy_o  (in_rdy),
    .msg_o     (msg_out)
  );

  assign bus.in_enq__RDY    = in_rdy;
  assign bus.out_enq__ENA   = out_ena;
  assign bus.out_enq_v      = msg_out.v;
  assign bus.out_enq_length = msg_out.length;

endmodule

// File: doc/adapter_from_bus.md
Name: adapter_from_bus

Overview:
- Gathers a stream of 32-bit bus beats, each with a last flag, into one 128-bit word plus a length.
- Inverse of the bus serializer; sits directly downstream of it on the receive path.
- Beat 0 lands in bits [31:0]. Length uses the serializer's convention: length = beats - 1.
- Emits one wide message per last-terminated burst, using the ENA/RDY method handshake.

Parameters:
- DATA_WIDTH, 32, width of one bus beat.
- WORDS, 4, beats per wide word; output width = DATA_WIDTH*WORDS (128).
- LEN_WIDTH, 16, width of the length field.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset, synchronous, active-high.
- in$enq__ENA  input  1  beat valid; asserted only when in$enq__RDY is high.
- in$enq$v  input  DATA_WIDTH  beat data.
- in$enq$last  input  1  final beat of the burst.
- in$enq__RDY  output  1  block can accept a beat this cycle.
- out$enq__ENA  output  1  wide message is being delivered this cycle.
- out$enq$v  output  DATA_WIDTH*WORDS  assembled word.
- out$enq$length  output  LEN_WIDTH  beats received minus 1.
- out$enq__RDY  input  1  consumer can accept.
- out$enq$overflow  output  1  present only with ADAPTER_FROM_BUS_OVERFLOW_EN.

Behaviour:
- Reset (synchronous, active-high):
  - All state is cleared: buffer = 0, count = 0, full = 0.
  - out$enq__ENA = 0, out$enq$v = 0, out$enq$length = 0; in$enq__RDY = 1 after reset.
  - Asserting RST mid-burst discards the partial message and any held output; nothing is emitted.
- States:
  - ACCUM (full=0): collecting beats.
  - FULL (full=1): holding a completed message.
- Accept condition: a beat is accepted when in$enq__ENA & in$enq__RDY.
- in$enq__RDY = !full | out$enq__RDY. This is a drain bypass: a message draining in the same cycle frees the slot for the next burst's first beat.
- Accepted beat with count < WORDS:
  - data is written to slice [count*DATA_WIDTH +: DATA_WIDTH].
  - count increments.
- Accepted beat with count >= WORDS: data is dropped; count keeps incrementing, saturating at all-ones (LEN_WIDTH bits).
- Accepted beat with last=1:
  - Output register receives the completed buffer, with unfilled slices zero.
  - out$enq$length = count_after - 1, saturating.
  - full is set; working buffer and count clear to 0 for the next burst.
- out$enq__ENA = full & out$enq__RDY. On that edge full clears, unless a new message completes in the same cycle, in which case full stays set with the new contents.
- Latency: the message is visible on out$enq$v the cycle after the last beat is accepted. Zero bubbles between bursts while out$enq__RDY stays high.
- Single-beat burst (first beat has last=1): length = 0, v = {96'b0, beat}.
- Output fields are stable while full & !out$enq__RDY; no beat is accepted in that state.
- Beats are accepted with in$enq__ENA=0 ignored; there is no timeout.

Optional Feature:
- Macro: ADAPTER_FROM_BUS_OVERFLOW_EN.
- Defined:
  - out$enq$overflow port exists.
  - It is a registered flag set when a burst exceeds WORDS beats, and it accompanies that message.
  - It clears with the message's consumption.
- Undefined:
  - Port absent; excess beats are silently dropped.
  - out$enq$length still reports the true count (saturating).

Decomposition:
- Shared package:
  - DATA_WIDTH, WORDS, LEN_WIDTH defaults.
  - Typedef for the wide message struct {v, length, overflow}.
  - Beat-index width constant $clog2(WORDS).
- One natural sub-module, adapter_from_bus_hold: a one-entry output holding register with bypass-ready logic. The main block keeps the accumulator and counter.

Test Plan:
- 4 beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on 4th), out$enq__RDY=1 -> next cycle out$enq__ENA=1, v=0x44444444_33333333_22222222_11111111, length=3.
- Single beat 0xDEADBEEF with last -> v=0x0..0_DEADBEEF, length=0.
- 2-beat burst while out$enq__RDY=0 -> in$enq__RDY=0 until out$enq__RDY rises. Then the message drains and a first beat is accepted in the same cycle; the next message is correct.
- 6-beat burst -> v holds beats 0..3, length=5; with ADAPTER_FROM_BUS_OVERFLOW_EN, overflow=1 on that message and 0 on the following 1-beat message.
- RST high after 2 of 4 beats, then a fresh 1-beat burst 0xA5 -> only one message, v=0x..A5, length=0.
- Back-to-back 4-beat bursts with out$enq__RDY=1 constant -> in$enq__RDY stays 1 throughout; one message every 4 cycles.
